// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter examples
// Contents:
//   COUNTER_WIDTH : default counter width, shared with the up counter
//   state_e       : down counter FSM states (IDLE, RUN)
package counter_pkg;

   localparam int COUNTER_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/down_counter_if.sv
// rtl/down_counter_if.sv - load handshake, controls and status of the down counter
// Signals:
//   load_valid / load_ready / load_value : start-value handshake
//   en, stop                             : count enable, abort
//   q, busy, done                        : current count, RUN flag, terminal pulse
// Modports:
//   master : producer/consumer side (drives load, en, stop)
//   slave  : the counter itself
interface down_counter_if
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             en;
   logic             stop;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_value, en, stop,
      input  load_ready, q, busy, done
   );

   modport slave (
      input  load_valid, load_value, en, stop,
      output load_ready, q, busy, done
   );

endinterface

// File: rtl/down_counter_core.sv
// rtl/down_counter_core.sv - count and saved-value register pair
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : capture value_i into both count and saved
//   value_i    : start value
//   clear_i    : force count to zero
//   reload_i   : copy saved value back into count
//   dec_i      : decrement count by one
//   q_o        : current count
module down_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             clear_i,
   input  logic             reload_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] saved_q, saved_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q     <= '0;
         saved_q <= '0;
      end else begin
         q_q     <= q_d;
         saved_q <= saved_d;
      end
   end

   // Controls are mutually exclusive from the FSM; the order here only
   // documents precedence should two ever coincide.
   always_comb begin
      q_d     = q_q;
      saved_d = saved_q;
      if (load_i) begin
         q_d     = value_i;
         saved_d = value_i;
      end else if (clear_i) begin
         q_d = '0;
      end else if (reload_i) begin
         q_d = saved_q;
      end else if (dec_i) begin
         q_d = q_q - WIDTH'(1);
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - programmable countdown timer with load handshake
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : down_counter_if.slave (load handshake, en, stop, q, busy, done)
// Build option:
//   DOWN_COUNTER_RELOAD_EN : on terminal count stay in RUN and reload the
//                            saved value instead of returning to IDLE
module down_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   down_counter_if.slave   bus
);

   state_e state_q, state_d;
   logic   done_q, done_d;

   logic             load;
   logic             clear;
   logic             reload;
   logic             dec;
   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load    = 1'b0;
      clear   = 1'b0;
      reload  = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // load_ready is high throughout IDLE, so valid alone accepts.
            if (bus.load_valid) begin
               load = 1'b1;
               if (bus.load_value != '0) begin
                  state_d = RUN;
               end else begin
                  // Zero-length count: terminal immediately, never busy.
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
               clear   = 1'b1;
            end else if (bus.en && q == WIDTH'(1)) begin
               done_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
               reload = 1'b1;
`else
               state_d = IDLE;
               clear   = 1'b1;
`endif
            end else if (bus.en) begin
               dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   down_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .value_i  (bus.load_value),
      .clear_i  (clear),
      .reload_i (reload),
      .dec_i    (dec),
      .q_o      (q)
   );

   assign bus.q          = q;
   assign bus.busy       = (state_q == RUN);
   assign bus.load_ready = (state_q == IDLE);
   assign bus.done       = done_q;

endmodule

// File: doc/down_counter.md
# down_counter

Programmable countdown timer, the load-driven, decrementing counterpart to the team's free-running 4-bit up counter. A producer hands it a start value over a valid/ready handshake. The block counts down to zero on enabled clocks, pulses `done` at terminal count, then either returns to idle or auto-reloads. It sits beside the up counter in the counter examples and serves as a periodic tick or timeout source for downstream logic.

## Interface
- `WIDTH`, default 4: counter and load-value width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `load_valid`  in  1  producer offers `load_value`.
- `load_ready`  out  1  block can accept a load.
- `load_value`  in  WIDTH  start count; 0 is legal.
- `en`  in  1  count enable; while low, the count holds.
- `stop`  in  1  abort the current count.
- `q`  out  WIDTH  current count.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at terminal count.

## Operation
- States are IDLE and RUN. An internal `saved` register holds the last accepted `load_value`.
- Reset (`rst`=0 at an edge) gives: state IDLE, `q`=0, `saved`=0, `busy`=0, `done`=0, `load_ready`=1.
- IDLE:
  - `load_ready`=1.
  - A load is accepted on an edge where `load_valid`=1 and `load_ready`=1. On that edge, `q`<=`load_value` and `saved`<=`load_value`.
  - If `load_value`≠0, the next state is RUN.
  - If `load_value`=0, the state stays IDLE and `done`=1 for the next cycle (zero-length count).
  - `en` and `stop` are ignored in IDLE.
- RUN:
  - `load_ready`=0 and `busy`=1. `load_valid` is ignored; there is no queuing.
  - Priority order at each edge is `stop` > terminal > decrement > hold.
  - `stop`=1: next state IDLE, `q`<=0, no `done`.
  - Terminal (`en`=1, `q`=1): `done`<=1, then the reload rule in Configuration applies.
  - Decrement (`en`=1, `q`>1): `q`<=`q`-1.
  - Hold (`en`=0): `q` unchanged.
- `done` is registered. It is high for exactly one cycle and low in every other case.
- Arithmetic: `q` never wraps below 0. The full range 1..2^WIDTH-1 is loadable; `q` never exceeds `saved`.
- Reset mid-RUN: the block returns to the reset values on that edge. No `done` pulse.
- `stop` on the terminal edge: `stop` wins. `q`=0, no `done`, no reload.

## Timing
- A load accepted at edge k makes `q`=N and `busy`=1 visible after edge k.
- With `en` held at 1, `q` decrements once per edge.
- `q`=0, `done`=1 and `busy`=0 appear together after edge k+N (non-reload build).
- Back-to-back operation: `load_ready`=1 in the same cycle `done` is high, so a new load can be accepted on the very next edge, with no dead cycle.
- Zero-length load: `done` is high after edge k and `busy` stays 0.
- Holding `en`=0 stretches latency one cycle per low cycle.

## Configuration
- The feature macro is `DOWN_COUNTER_RELOAD_EN`.
- Undefined: on terminal count, next state IDLE and `q`<=0.
- Defined: on terminal count, state stays RUN and `q`<=`saved`, so `q` never shows 0. With `en`=1, `done` pulses every `saved` cycles. Exit is only by `stop` or reset. `load_ready` stays 0 throughout.
- Zero-length loads behave the same in both builds.

## Structure
- Package `counter_pkg`:
  - state typedef enum {IDLE, RUN};
  - default width constant `COUNTER_WIDTH`=4, shared with the up counter.
- One natural sub-module, `down_counter_core`, holds the `q`/`saved` register pair with load, decrement and reload controls. The top level holds the FSM and handshake.

## Test plan
- Reset hold: `rst`=0 for 2 edges with random inputs -> `q`=0, `busy`=0, `done`=0, `load_ready`=1.
- Load 5 with `en`=1 -> `q` reads 5,4,3,2,1,0. `done`=1 only in the cycle `q`=0, which is 5 edges after acceptance. `load_ready`=0 throughout RUN.
- Load 3 while toggling `en` 1,0,1,1 -> `q` reads 3,2,2,1,0 and `done` fires one cycle late. `load_valid`=1 during RUN is not accepted.
- `stop` while `q`=1 and `en`=1 -> `q`=0 with no `done`. Load 0 -> `done` pulse and `busy` stays 0. `rst`=0 mid-count at `q`=7 -> reset values, no `done`.
- Back-to-back: assert `load_valid` with value 2 during the `done` cycle -> accepted on the next edge. Load 15 (`WIDTH`=4) -> 15 decrements, no wrap.
- With `DOWN_COUNTER_RELOAD_EN`, load 4 and `en`=1 -> `q` reads 4,3,2,1,4,3,... `done` pulses every 4 cycles, and `stop` returns the block to IDLE.
